// File: rtl/write_back_queue.sv
// write_back_queue: in-order buffer between MEM/WB and the register-file write port.
// The register file serves a read or a write each cycle, so completed results wait here
// until decode is not reading. A full queue forces a drain regardless of decode.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   inMemRegWrite       MEM/WB result valid and targets a register
//   inMemToReg          1: write inMemReadData, 0: write inMemAluResult
//   inMemWriteReg       destination register
//   inMemAluResult      ALU result
//   inMemReadData       load result
//   inIdReadReq         decode reads the register file this cycle
//   inIdRsReg/RtReg     decode source registers
//   outRegWrite         register-file write enable (one cycle per entry)
//   outWriteReg         register-file write address (holds between writes)
//   outWriteData        register-file write data (holds between writes)
//   outIdHazard         a decode source matches a pending or incoming write
//   outPipeStall        queue full; upstream holds its result
//   outQueueCount       number of valid entries
module write_back_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inMemRegWrite,
  input  logic                     inMemToReg,
  input  logic [ADDR_W-1:0]        inMemWriteReg,
  input  logic [DATA_W-1:0]        inMemAluResult,
  input  logic [DATA_W-1:0]        inMemReadData,
  input  logic                     inIdReadReq,
  input  logic [ADDR_W-1:0]        inIdRsReg,
  input  logic [ADDR_W-1:0]        inIdRtReg,
  output logic                     outRegWrite,
  output logic [ADDR_W-1:0]        outWriteReg,
  output logic [DATA_W-1:0]        outWriteData,
  output logic                     outIdHazard,
  output logic                     outPipeStall,
  output logic [$clog2(DEPTH):0]   outQueueCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;

  logic              wr_q;
  logic [ADDR_W-1:0] wr_reg_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              full;
  logic              do_push;
  logic              do_drain;
  logic [DATA_W-1:0] in_data;
  logic              hit;

  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    // A full queue rejects the push even if it drains on the same edge.
    do_push  = inMemRegWrite && !full;
    do_drain = (count_q != '0) && (!inIdReadReq || full);
    in_data  = inMemToReg ? inMemReadData : inMemAluResult;

    count_d = count_q;
    if (do_push && !do_drain) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_drain) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Hazard covers queued entries plus the result being presented this cycle,
  // whether or not it is accepted (a stalled result is still pending).
  always_comb begin
    hit = inMemRegWrite &&
          ((inMemWriteReg == inIdRsReg) || (inMemWriteReg == inIdRtReg));
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ((ent_reg_q[i] == inIdRsReg) || (ent_reg_q[i] == inIdRtReg))) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      wr_q      <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wr_q    <= do_drain;
      // Push and drain never target the same slot: drain needs count>0 and
      // a full queue blocks the push.
      if (do_push) begin
        ent_reg_q[tail_q]  <= inMemWriteReg;
        ent_data_q[tail_q] <= in_data;
        valid_q[tail_q]    <= 1'b1;
        tail_q             <= tail_q + PtrW'(1);
      end
      if (do_drain) begin
        wr_reg_q        <= ent_reg_q[head_q];
        wr_data_q       <= ent_data_q[head_q];
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
    end
  end

  assign outRegWrite   = wr_q;
  assign outWriteReg   = wr_reg_q;
  assign outWriteData  = wr_data_q;
  assign outIdHazard   = inIdReadReq && hit;
  assign outPipeStall  = full;
  assign outQueueCount = count_q;

endmodule

// File: tb/tb_write_back_queue.sv
module tb_write_back_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inMemRegWrite = 1'b0;
  logic        inMemToReg = 1'b0;
  logic [4:0]  inMemWriteReg = '0;
  logic [31:0] inMemAluResult = '0;
  logic [31:0] inMemReadData = '0;
  logic        inIdReadReq = 1'b0;
  logic [4:0]  inIdRsReg = '0;
  logic [4:0]  inIdRtReg = '0;
  logic        outRegWrite;
  logic [4:0]  outWriteReg;
  logic [31:0] outWriteData;
  logic        outIdHazard;
  logic        outPipeStall;
  logic [2:0]  outQueueCount;

  write_back_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .inMemRegWrite  (inMemRegWrite),
    .inMemToReg     (inMemToReg),
    .inMemWriteReg  (inMemWriteReg),
    .inMemAluResult (inMemAluResult),
    .inMemReadData  (inMemReadData),
    .inIdReadReq    (inIdReadReq),
    .inIdRsReg      (inIdRsReg),
    .inIdRtReg      (inIdRtReg),
    .outRegWrite    (outRegWrite),
    .outWriteReg    (outWriteReg),
    .outWriteData   (outWriteData),
    .outIdHazard    (outIdHazard),
    .outPipeStall   (outPipeStall),
    .outQueueCount  (outQueueCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   mcount = 0;
  logic exp_wr = 1'b0;
  logic mon_en = 1'b0;

  // Drive one cycle of stimulus at the falling edge and advance the reference model.
  task automatic step(input logic v, input logic ts, input logic [4:0] wr,
                      input logic [31:0] alu, input logic [31:0] rd, input logic rq,
                      input logic [4:0] rs, input logic [4:0] rt);
    logic push_ok, drn;
    ent_t e;
    @(negedge clk);
    inMemRegWrite  = v;
    inMemToReg     = ts;
    inMemWriteReg  = wr;
    inMemAluResult = alu;
    inMemReadData  = rd;
    inIdReadReq    = rq;
    inIdRsReg      = rs;
    inIdRtReg      = rt;
    #1;
    push_ok = v && (mcount != DEPTH);
    drn     = (mcount != 0) && (!rq || (mcount == DEPTH));
    if (push_ok) begin
      e.r = wr;
      e.d = ts ? rd : alu;
      sb.push_back(e);
    end
    mcount = mcount + int'(push_ok) - int'(drn);
    exp_wr = drn;
  endtask

  task automatic idle(input logic rq);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rq, 5'd31, 5'd31);
  endtask

  // Scoreboard monitor: every write pulse pops and checks the oldest expected entry.
  always begin
    ent_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      n_checks++;
      if (outRegWrite !== exp_wr) begin
        n_fail++;
        $display("FAIL write_enable: got %b expected %b at %0t", outRegWrite, exp_wr, $time);
      end
      if (outRegWrite === 1'b1) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got reg %0d data %h expected no write at %0t",
                   outWriteReg, outWriteData, $time);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (outWriteReg !== e.r || outWriteData !== e.d) begin
            n_fail++;
            $display("FAIL write_entry: got reg %0d data %h expected reg %0d data %h at %0t",
                     outWriteReg, outWriteData, e.r, e.d, $time);
          end
        end
      end
    end
  end

  task automatic test_reset;
    #12;
    n_checks++;
    if (outRegWrite !== 1'b0 || outWriteReg !== 5'd0 || outWriteData !== 32'd0 ||
        outQueueCount !== 3'd0 || outPipeStall !== 1'b0 || outIdHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%b reg=%0d data=%h cnt=%0d stall=%b haz=%b expected all 0",
               outRegWrite, outWriteReg, outWriteData, outQueueCount, outPipeStall, outIdHazard);
    end
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    step(1'b1, 1'b0, 5'd3, 32'h0000_002A, 32'h0, 1'b0, 5'd31, 5'd31);
    idle(1'b0);
    n_checks++;
    if (outQueueCount !== 3'd1) begin
      n_fail++;
      $display("FAIL single_count_one: got %0d expected 1", outQueueCount);
    end
    idle(1'b0);
    n_checks++;
    if (outQueueCount !== 3'd0) begin
      n_fail++;
      $display("FAIL single_count_zero: got %0d expected 0", outQueueCount);
    end
    idle(1'b0);
  endtask

  task automatic test_load_select;
    step(1'b1, 1'b1, 5'd7, 32'h0000_0011, 32'hDEAD_BEEF, 1'b0, 5'd31, 5'd31);
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic test_deferred;
    step(1'b1, 1'b0, 5'd1, 32'h100, 32'h0, 1'b1, 5'd31, 5'd31);
    step(1'b1, 1'b1, 5'd2, 32'h0, 32'h200, 1'b1, 5'd31, 5'd31);
    step(1'b1, 1'b0, 5'd1, 32'h300, 32'h0, 1'b1, 5'd31, 5'd31);
    idle(1'b1);
    n_checks++;
    if (outQueueCount !== 3'd3) begin
      n_fail++;
      $display("FAIL deferred_count: got %0d expected 3", outQueueCount);
    end
    repeat (4) idle(1'b0);
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 5'(10 + i), 32'(32'hA0 + i), 32'h0, 1'b1, 5'd31, 5'd31);
    end
    // Fifth result presented while full: refused, while entry 0 is forced out.
    step(1'b1, 1'b0, 5'd14, 32'hE0, 32'h0, 1'b1, 5'd31, 5'd31);
    n_checks++;
    if (outPipeStall !== 1'b1 || outQueueCount !== 3'd4) begin
      n_fail++;
      $display("FAIL full_stall: got stall=%b cnt=%0d expected stall=1 cnt=4",
               outPipeStall, outQueueCount);
    end
    step(1'b1, 1'b0, 5'd14, 32'hE0, 32'h0, 1'b1, 5'd31, 5'd31);
    n_checks++;
    if (outPipeStall !== 1'b0 || outQueueCount !== 3'd3) begin
      n_fail++;
      $display("FAIL full_release: got stall=%b cnt=%0d expected stall=0 cnt=3",
               outPipeStall, outQueueCount);
    end
    repeat (6) idle(1'b0);
  endtask

  task automatic test_hazard;
    // Incoming result alone matches (queue empty).
    step(1'b1, 1'b0, 5'd5, 32'h555, 32'h0, 1'b1, 5'd5, 5'd0);
    n_checks++;
    if (outIdHazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_incoming: got %b expected 1", outIdHazard);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd0);
    n_checks++;
    if (outIdHazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_queued_rs: got %b expected 1", outIdHazard);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 5'd5);
    n_checks++;
    if (outIdHazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_queued_rt: got %b expected 1", outIdHazard);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9);
    n_checks++;
    if (outIdHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_no_match: got %b expected 0", outIdHazard);
    end
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd5);
    n_checks++;
    if (outIdHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_after_drain: got %b expected 0", outIdHazard);
    end
    idle(1'b0);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5'(20 + i), 32'(32'hC0 + i), 32'h0, 1'b1, 5'd31, 5'd31);
    end
    idle(1'b1);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    sb.delete();
    mcount = 0;
    exp_wr = 1'b0;
    #1;
    n_checks++;
    if (outQueueCount !== 3'd0 || outWriteReg !== 5'd0 || outWriteData !== 32'd0 ||
        outRegWrite !== 1'b0 || outPipeStall !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got cnt=%0d reg=%0d data=%h we=%b stall=%b expected all 0",
               outQueueCount, outWriteReg, outWriteData, outRegWrite, outPipeStall);
    end
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (4) idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_load_select();
    test_deferred();
    test_full();
    test_hazard();
    test_async_reset();
    idle(1'b0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
